// File: rtl/selsplit_pkg.sv
// Shared definitions for the selective splitter: FSM state encoding and
// legal parameter ranges.
package selsplit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        HOLD = ST_HOLD
    } selState_t;

    localparam int N_OUT_MIN      = 2;
    localparam int N_OUT_MAX      = 16;
    localparam int FREE_DELAY_MIN = 0;
    localparam int FREE_DELAY_MAX = 15;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/selsplit_ack_tap.sv
// Per-channel sticky acknowledge: set by a free on a selected channel while
// waiting, cleared when the splitter returns to idle.
module selsplit_ack_tap (
    input  logic clk,
    input  logic rst,
    input  logic inWait,
    input  logic free,
    input  logic sel,
    input  logic clr,
    output logic ack
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ack <= 1'b0;
        else if (clr)
            ack <= 1'b0;
        else if (inWait && free && sel)
            ack <= 1'b1;
    end

endmodule

// File: rtl/sel_split_n_d.sv
// Selective 1:N request splitter with join-on-free and a programmable idle
// delay before releasing upstream. Define SELSPLIT_HOLD_DATA_EN for per-channel payload hold.
module sel_split_n_d
    import selsplit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_OUT      = 2,
    parameter int FREE_DELAY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_drive,
    input  logic [N_OUT-1:0]            i_valid,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic [N_OUT-1:0]            i_freeNext,
    output logic [N_OUT-1:0]            o_driveNext,
    output logic [N_OUT*DATA_WIDTH-1:0] o_data,
    output logic                        o_free,
    output logic                        o_busy,
    output logic                        o_drop
);

    if (N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX) begin : gBadNOut
        $error("sel_split_n_d: N_OUT out of range");
    end
    if (FREE_DELAY < FREE_DELAY_MIN || FREE_DELAY > FREE_DELAY_MAX) begin : gBadDelay
        $error("sel_split_n_d: FREE_DELAY out of range");
    end

    localparam logic [CNT_W-1:0] HOLD_INIT =
        (FREE_DELAY > 0) ? CNT_W'(FREE_DELAY - 1) : '0;

    selState_t              state;
    logic [N_OUT-1:0]       maskR;
    logic [N_OUT-1:0]       ackVec;
    logic [CNT_W-1:0]       cnt;
    logic [N_OUT-1:0]       driveNextR;
    logic                   freeR;
    logic                   dropR;
    logic                   inWait;
    logic                   done;
    logic                   enterIdle;

    assign inWait = (state == WAIT);
    // A free arriving in the completing cycle counts without waiting for its sticky bit.
    assign done   = inWait && ((ackVec | (i_freeNext & maskR)) == maskR);
    assign enterIdle = (done && FREE_DELAY == 0) || (state == HOLD && cnt == '0);

    for (genvar k = 0; k < N_OUT; k++) begin : gAck
        selsplit_ack_tap uTap (
            .clk    (clk),
            .rst    (rst),
            .inWait (inWait),
            .free   (i_freeNext[k]),
            .sel    (maskR[k]),
            .clr    (enterIdle),
            .ack    (ackVec[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            maskR      <= '0;
            cnt        <= '0;
            driveNextR <= '0;
            freeR      <= 1'b0;
            dropR      <= 1'b0;
        end else begin
            driveNextR <= '0;
            freeR      <= 1'b0;
            dropR      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_drive) begin
                        maskR      <= i_valid;
                        driveNextR <= i_valid;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    dropR <= i_drive;
                    if (done) begin
                        if (FREE_DELAY == 0) begin
                            state <= IDLE;
                            freeR <= 1'b1;
                        end else begin
                            state <= HOLD;
                            cnt   <= HOLD_INIT;
                        end
                    end
                end
                HOLD: begin
                    dropR <= i_drive;
                    if (cnt == '0) begin
                        state <= IDLE;
                        freeR <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SELSPLIT_HOLD_DATA_EN
    logic [N_OUT-1:0][DATA_WIDTH-1:0] payloadR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payloadR <= '0;
        end else if (state == IDLE && i_drive) begin
            for (int k = 0; k < N_OUT; k++)
                if (i_valid[k]) payloadR[k] <= i_data;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : gData
        assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = payloadR[k];
    end
`else
    logic [DATA_WIDTH-1:0] payloadR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            payloadR <= '0;
        else if (state == IDLE && i_drive)
            payloadR <= i_data;
    end

    for (genvar k = 0; k < N_OUT; k++) begin : gData
        assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = payloadR;
    end
`endif

    assign o_driveNext = driveNextR;
    assign o_free      = freeR;
    assign o_drop      = dropR;
    assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_sel_split_n_d.sv
// Directed bench for sel_split_n_d: instance A (N_OUT=4, FREE_DELAY=2) and
// instance B (N_OUT=2, FREE_DELAY=0).
module tb_sel_split_n_d;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          aDrive = 0;
    logic [3:0]    aValid = 0;
    logic [DW-1:0] aData  = 0;
    logic [3:0]    aFree  = 0;
    logic [3:0]    aDriveNext;
    logic [4*DW-1:0] aOData;
    logic          aOFree, aBusy, aDrop;

    logic          bDrive = 0;
    logic [1:0]    bValid = 0;
    logic [DW-1:0] bData  = 0;
    logic [1:0]    bFree  = 0;
    logic [1:0]    bDriveNext;
    logic [2*DW-1:0] bOData;
    logic          bOFree, bBusy, bDrop;

    int errors = 0;
    int checks = 0;

    sel_split_n_d #(.DATA_WIDTH(DW), .N_OUT(4), .FREE_DELAY(2)) dutA (
        .clk(clk), .rst(rst), .i_drive(aDrive), .i_valid(aValid), .i_data(aData),
        .i_freeNext(aFree), .o_driveNext(aDriveNext), .o_data(aOData),
        .o_free(aOFree), .o_busy(aBusy), .o_drop(aDrop)
    );

    sel_split_n_d #(.DATA_WIDTH(DW), .N_OUT(2), .FREE_DELAY(0)) dutB (
        .clk(clk), .rst(rst), .i_drive(bDrive), .i_valid(bValid), .i_data(bData),
        .i_freeNext(bFree), .o_driveNext(bDriveNext), .o_data(bOData),
        .o_free(bOFree), .o_busy(bBusy), .o_drop(bDrop)
    );

    // Advance one cycle; inputs set after this are sampled on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if ({aDriveNext, aOFree, aBusy, aDrop} !== 7'd0) begin errors++; $display("FAIL reset_ctrlA got=%b want=0", {aDriveNext, aOFree, aBusy, aDrop}); end
        checks++; if (aOData !== '0) begin errors++; $display("FAIL reset_dataA got=%h want=0", aOData); end
        checks++; if ({bDriveNext, bOFree, bBusy, bDrop, bOData} !== '0) begin errors++; $display("FAIL reset_B got=%h want=0", {bDriveNext, bOFree, bBusy, bDrop, bOData}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_split_join();
        aDrive = 1; aValid = 4'b0101; aData = 32'hA5A5A5A5;
        tick(); aDrive = 0; aValid = 0;                                   // t+1
        checks++; if (aDriveNext !== 4'b0101) begin errors++; $display("FAIL split_drive got=%b want=0101", aDriveNext); end
        checks++; if (aOData[0 +: DW] !== 32'hA5A5A5A5 || aOData[2*DW +: DW] !== 32'hA5A5A5A5) begin errors++; $display("FAIL split_data got=%h want=a5a5a5a5 on ch0/ch2", aOData); end
        checks++; if (aBusy !== 1'b1) begin errors++; $display("FAIL split_busy got=%b want=1", aBusy); end
        tick();                                                          // t+2
        checks++; if (aDriveNext !== 4'b0000) begin errors++; $display("FAIL split_drive_once got=%b want=0000", aDriveNext); end
        tick(); aFree = 4'b0001;                                         // t+3
        tick(); aFree = 4'b0001;                                         // t+4 repeat free
        tick(); aFree = 4'b0100;                                         // t+5
        tick(); aFree = 0;                                               // t+6
        checks++; if (aOFree !== 1'b0 || aBusy !== 1'b1) begin errors++; $display("FAIL split_hold6 free=%b busy=%b want free=0 busy=1", aOFree, aBusy); end
        tick();                                                          // t+7
        checks++; if (aOFree !== 1'b0 || aBusy !== 1'b1) begin errors++; $display("FAIL split_hold7 free=%b busy=%b want free=0 busy=1", aOFree, aBusy); end
        tick();                                                          // t+8
        checks++; if (aOFree !== 1'b1 || aBusy !== 1'b0) begin errors++; $display("FAIL split_free8 free=%b busy=%b want free=1 busy=0", aOFree, aBusy); end
        tick();                                                          // t+9
        checks++; if (aOFree !== 1'b0) begin errors++; $display("FAIL split_free_pulse got=%b want=0", aOFree); end
    endtask

    task automatic test_empty_mask();
        bDrive = 1; bValid = 2'b00; bData = 32'h0;
        tick(); bDrive = 0;                                              // t+1
        checks++; if (bDriveNext !== 2'b00 || bBusy !== 1'b1 || bOFree !== 1'b0) begin errors++; $display("FAIL empty_t1 drv=%b busy=%b free=%b want 00/1/0", bDriveNext, bBusy, bOFree); end
        tick();                                                          // t+2
        checks++; if (bOFree !== 1'b1 || bBusy !== 1'b0) begin errors++; $display("FAIL empty_free free=%b busy=%b want 1/0", bOFree, bBusy); end
        tick();
    endtask

    task automatic test_drop();
        aDrive = 1; aValid = 4'b0101; aData = 32'h12345678;
        tick(); aDrive = 0;                                              // t+1
        checks++; if (aDriveNext !== 4'b0101) begin errors++; $display("FAIL drop_drive got=%b want=0101", aDriveNext); end
        tick(); aDrive = 1; aValid = 4'b1111; aData = 32'hDEADBEEF;      // t+2
        tick(); aDrive = 0; aValid = 0;                                  // t+3
        checks++; if (aDrop !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b want=1", aDrop); end
        checks++; if (aOData[0 +: DW] !== 32'h12345678 || aDriveNext !== 4'b0000) begin errors++; $display("FAIL drop_unchanged data=%h drv=%b want 12345678/0000", aOData[0 +: DW], aDriveNext); end
        tick(); aFree = 4'b0010;                                         // t+4
        checks++; if (aDrop !== 1'b0) begin errors++; $display("FAIL drop_once got=%b want=0", aDrop); end
        tick(); aFree = 0;                                               // t+5
        tick();                                                          // t+6
        checks++; if (aBusy !== 1'b1 || aOFree !== 1'b0) begin errors++; $display("FAIL drop_unsel busy=%b free=%b want 1/0", aBusy, aOFree); end
        aFree = 4'b0101;
        tick(); aFree = 0;                                               // t+7
        tick(); tick();                                                  // t+9
        checks++; if (aOFree !== 1'b1 || aBusy !== 1'b0) begin errors++; $display("FAIL drop_complete free=%b busy=%b want 1/0", aOFree, aBusy); end
        tick();
    endtask

    task automatic test_reset_midwait();
        aDrive = 1; aValid = 4'b0101; aData = 32'h00000005;
        tick(); aDrive = 0;                                              // t+1
        tick(); aFree = 4'b0001;                                         // t+2
        tick(); aFree = 0;                                               // t+3
        rst = 1'b1;
        #1;
        checks++; if ({aDriveNext, aOFree, aBusy, aDrop} !== 7'd0 || aOData !== '0) begin errors++; $display("FAIL rst_async ctrl=%b data=%h want 0", {aDriveNext, aOFree, aBusy, aDrop}, aOData); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (aOFree !== 1'b0 || aBusy !== 1'b0) begin errors++; $display("FAIL rst_nofree cyc=%0d free=%b busy=%b want 0/0", i, aOFree, aBusy); end
        end
        aDrive = 1; aValid = 4'b0100; aData = 32'h77;
        tick(); aDrive = 0;                                              // t+1
        checks++; if (aDriveNext !== 4'b0100 || aOData[2*DW +: DW] !== 32'h77) begin errors++; $display("FAIL rst_restart drv=%b data=%h want 0100/77", aDriveNext, aOData[2*DW +: DW]); end
        tick(); aFree = 4'b0100;                                         // t+2
        tick(); aFree = 0;                                               // t+3
        tick(); tick();                                                  // t+5
        checks++; if (aOFree !== 1'b1) begin errors++; $display("FAIL rst_restart_free got=%b want=1", aOFree); end
    endtask

    task automatic test_back_to_back();
        // Entered in the o_free cycle of the previous transaction.
        aDrive = 1; aValid = 4'b1000; aData = 32'h99;
        tick(); aDrive = 0;
        checks++; if (aDriveNext !== 4'b1000 || aBusy !== 1'b1) begin errors++; $display("FAIL b2b_accept drv=%b busy=%b want 1000/1", aDriveNext, aBusy); end
        checks++; if (aOData[3*DW +: DW] !== 32'h99) begin errors++; $display("FAIL b2b_data got=%h want=99", aOData[3*DW +: DW]); end
        aFree = 4'b1000;
        tick(); aFree = 0;
        tick(); tick();
        checks++; if (aOFree !== 1'b1) begin errors++; $display("FAIL b2b_free got=%b want=1", aOFree); end
        tick();
    endtask

    task automatic test_hold_data();
        logic [DW-1:0] expCh1;
`ifdef SELSPLIT_HOLD_DATA_EN
        expCh1 = 32'h11;
`else
        expCh1 = 32'h22;
`endif
        bDrive = 1; bValid = 2'b11; bData = 32'h11;
        tick(); bDrive = 0; bFree = 2'b11;                               // t+1
        tick(); bFree = 0;                                               // t+2
        checks++; if (bOFree !== 1'b1) begin errors++; $display("FAIL hold_txn1_free got=%b want=1", bOFree); end
        bDrive = 1; bValid = 2'b01; bData = 32'h22;
        tick(); bDrive = 0; bValid = 0;                                  // t+3
        checks++; if (bDriveNext !== 2'b01) begin errors++; $display("FAIL hold_txn2_drive got=%b want=01", bDriveNext); end
        checks++; if (bOData[0 +: DW] !== 32'h22) begin errors++; $display("FAIL hold_ch0 got=%h want=22", bOData[0 +: DW]); end
        checks++; if (bOData[DW +: DW] !== expCh1) begin errors++; $display("FAIL hold_ch1 got=%h want=%h", bOData[DW +: DW], expCh1); end
        bFree = 2'b01;
        tick(); bFree = 0;                                               // t+4
        checks++; if (bOFree !== 1'b1 || bBusy !== 1'b0) begin errors++; $display("FAIL hold_txn2_free free=%b busy=%b want 1/0", bOFree, bBusy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_split_join();
        test_empty_mask();
        test_drop();
        test_reset_midwait();
        test_back_to_back();
        test_hold_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_split_n_d.md
SEL_SPLIT_N_D -- requirements
Module: sel_split_n_d

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter N_OUT, default 2, output channel count, legal range 2..16.
REQ-003 SHALL have parameter FREE_DELAY, default 2, idle cycles between last downstream free and o_free, legal range 0..15.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port i_drive  input  1  one-cycle upstream request pulse.
REQ-007 SHALL have port i_valid  input  N_OUT  per-channel select mask, sampled with i_drive.
REQ-008 SHALL have port i_data  input  DATA_WIDTH  payload, sampled with i_drive.
REQ-009 SHALL have port i_freeNext  input  N_OUT  one-cycle downstream free pulses, one bit per channel.
REQ-010 SHALL have port o_driveNext  output  N_OUT  one-cycle downstream request pulses.
REQ-011 SHALL have port o_data  output  N_OUT*DATA_WIDTH  per-channel payload, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port o_free  output  1  one-cycle upstream free pulse.
REQ-013 SHALL have port o_busy  output  1  high while a transaction is in flight.
REQ-014 SHALL have port o_drop  output  1  one-cycle pulse when i_drive arrives while busy.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, HOLD; o_busy = (state != IDLE).
REQ-016 SHALL, on i_drive in IDLE at cycle t, capture i_valid into mask_r and i_data into payload register(s), and enter WAIT at t+1.
REQ-017 SHALL assert o_driveNext[k] = mask_r[k] for exactly cycle t+1; o_data is valid from t+1.
REQ-018 SHALL, in WAIT, set sticky ack_r[k] on i_freeNext[k] & mask_r[k]; frees on unselected channels are ignored, and repeated frees are idempotent.
REQ-019 SHALL treat completion at cycle a as the first WAIT cycle where (ack_r | (i_freeNext & mask_r)) == mask_r; mask_r == 0 completes at t+1.
REQ-020 SHALL, after completion at a, go to HOLD for FREE_DELAY cycles (a+1..a+FREE_DELAY), then enter IDLE at a+1+FREE_DELAY with o_free high for that one cycle; FREE_DELAY=0 skips HOLD.
REQ-021 SHALL accept a new i_drive in the same cycle o_free is high.
REQ-022 SHALL ignore i_drive in WAIT/HOLD, leave state unchanged, and pulse o_drop in the next cycle.
REQ-023 SHALL ignore i_freeNext in IDLE and HOLD.
REQ-024 SHALL clear ack_r on entry to IDLE.

Reset
REQ-025 SHALL, on rst, asynchronously force state IDLE, mask_r/ack_r/counter 0, o_driveNext/o_free/o_drop/o_busy 0, o_data 0.
REQ-026 SHALL abandon any in-flight transaction on reset without emitting o_free.

Configuration
REQ-027 SHALL, when SELSPLIT_HOLD_DATA_EN is defined, keep one payload register per channel, loaded only if its channel is selected and held until the next transaction selecting it.
REQ-028 SHALL, when SELSPLIT_HOLD_DATA_EN is undefined, keep one shared payload register, loaded on every accepted i_drive and broadcast to all N_OUT slices.

Structure
REQ-029 SHALL place the FSM state enum and the N_OUT/FREE_DELAY range limits in shared package selsplit_pkg.
REQ-030 SHALL instantiate per-channel sticky-ack sub-module selsplit_ack_tap (set on masked free, clear on IDLE entry, async reset).

Verification
REQ-031 SHALL verify: N_OUT=4, FREE_DELAY=2, drive at t with i_valid=4'b0101, data 0xA5A5A5A5 -> o_driveNext=4'b0101 at t+1 only; frees ch0 at t+3, ch2 at t+5 -> o_free at t+8.
REQ-032 SHALL verify: i_valid=0 at t, FREE_DELAY=0 -> no o_driveNext, o_free at t+2.
REQ-033 SHALL verify: i_drive at t+2 while WAIT -> o_drop at t+3, mask_r/payload unchanged; free on unselected ch1 -> no completion.
REQ-034 SHALL verify: rst asserted mid-WAIT after one of two acks -> all outputs 0 immediately, no o_free; next drive restarts cleanly.
REQ-035 SHALL verify: with SELSPLIT_HOLD_DATA_EN, txn1 valid=2'b11 data 0x11, txn2 valid=2'b01 data 0x22 -> o_data ch0=0x22, ch1=0x11; without the macro both slices=0x22.
REQ-036 SHALL verify: back-to-back drive in the o_free cycle -> accepted, o_driveNext next cycle.
